// File: rtl/rx_port_buffer_pkg.sv
// rx_port_buffer_pkg
//   Shared constants and types for the RX port buffer: DW / word widths,
//   WR_EN encodings, packer state enum and a DW-count helper.
package rx_port_buffer_pkg;

  localparam int DW_W   = 32;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    EN_IDLE = 2'b00,
    EN_DW0  = 2'b01,
    EN_DW1  = 2'b10,
    EN_BOTH = 2'b11
  } wrEnT;

  typedef enum logic {
    PACK       = 1'b0,
    FLUSH_PEND = 1'b1
  } packStateT;

  // Number of DWs enabled in a beat (0..2).
  function automatic logic [1:0] dwCount(input logic [1:0] en);
    return {1'b0, en[0]} + {1'b0, en[1]};
  endfunction

endpackage

// File: rtl/rx_port_packer_64.sv
// rx_port_packer_64
//   Packs DW-granular RX payload into dense 64-bit words. Holds at most
//   one residue DW; on flush emits any trailing DW zero-padded in the
//   upper half. A flush that leaves a full word plus one DW spends one
//   extra cycle in FLUSH_PEND to emit the padded leftover; input arriving
//   in that cycle is dropped and flagged.
//   Ports: CLK, RST_N (sync, active-low), wrData/wrEn/wrFlush (input
//          beat), word/push (registered packed word and its strobe),
//          gapErr (registered one-cycle pulse on flush-gap violation).
module rx_port_packer_64
  import rx_port_buffer_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WORD_W-1:0] wrData,
  input  logic [1:0]        wrEn,
  input  logic              wrFlush,
  output logic [WORD_W-1:0] word,
  output logic              push,
  output logic              gapErr
);

  packStateT         rState, nState;
  logic              rResV, nResV;
  logic [DW_W-1:0]   rRes, nRes;
  logic [DW_W-1:0]   rPend, nPend;
  logic [WORD_W-1:0] rWord, nWord;
  logic              rPush, nPush;
  logic              rGap, nGap;

  logic [DW_W-1:0]   inFirst, inSecond;
  logic [DW_W-1:0]   d0, d1, d2;
  logic [1:0]        n;

  always_comb begin
    // With only DW1 enabled it is the first incoming DW.
    inFirst  = wrEn[0] ? wrData[DW_W-1:0] : wrData[WORD_W-1:DW_W];
    inSecond = wrData[WORD_W-1:DW_W];
    n        = {1'b0, rResV} + dwCount(wrEn);

    // Oldest-first ordering of residue + incoming DWs.
    if (rResV) begin
      d0 = rRes;
      d1 = inFirst;
      d2 = inSecond;
    end else begin
      d0 = inFirst;
      d1 = inSecond;
      d2 = inSecond;
    end

    nState = rState;
    nResV  = rResV;
    nRes   = rRes;
    nPend  = rPend;
    nWord  = rWord;
    nPush  = 1'b0;
    nGap   = 1'b0;

    case (rState)
      FLUSH_PEND: begin
        nWord  = {{DW_W{1'b0}}, rPend};
        nPush  = 1'b1;
        nGap   = (wrEn != EN_IDLE);
        nResV  = 1'b0;
        nState = PACK;
      end
      default: begin
        if (n >= 2'd2) begin
          nWord = {d1, d0};
          nPush = 1'b1;
          if (n == 2'd3) begin
            if (wrFlush) begin
              nPend  = d2;
              nResV  = 1'b0;
              nState = FLUSH_PEND;
            end else begin
              nRes  = d2;
              nResV = 1'b1;
            end
          end else begin
            nResV = 1'b0;
          end
        end else if (n == 2'd1) begin
          if (wrFlush) begin
            nWord = {{DW_W{1'b0}}, d0};
            nPush = 1'b1;
            nResV = 1'b0;
          end else begin
            nRes  = d0;
            nResV = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rState <= PACK;
      rResV  <= 1'b0;
      rRes   <= '0;
      rPend  <= '0;
      rWord  <= '0;
      rPush  <= 1'b0;
      rGap   <= 1'b0;
    end else begin
      rState <= nState;
      rResV  <= nResV;
      rRes   <= nRes;
      rPend  <= nPend;
      rWord  <= nWord;
      rPush  <= nPush;
      rGap   <= nGap;
    end
  end

  assign word   = rWord;
  assign push   = rPush;
  assign gapErr = rGap;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock block-RAM FIFO with a registered read port (data appears
//   the cycle after RD_EN is sampled). Writes when full and reads when
//   empty are ignored.
//   Ports: CLK, RST_N (sync, active-low), WR_EN/WR_DATA/FULL,
//          RD_EN/RD_DATA/EMPTY, COUNT (entries held; 0 unless
//          C_PROVIDE_COUNT).
module sync_fifo #(
  parameter int C_WIDTH         = 64,
  parameter int C_DEPTH         = 512,
  parameter int C_PROVIDE_COUNT = 0,
  localparam int C_PTR_W        = $clog2(C_DEPTH),
  localparam int C_COUNT_W      = $clog2((2**C_PTR_W) + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 WR_EN,
  input  logic [C_WIDTH-1:0]   WR_DATA,
  output logic                 FULL,
  input  logic                 RD_EN,
  output logic [C_WIDTH-1:0]   RD_DATA,
  output logic                 EMPTY,
  output logic [C_COUNT_W-1:0] COUNT
);

  logic [C_WIDTH-1:0]   mem [C_DEPTH];
  logic [C_PTR_W-1:0]   rWrPtr, rRdPtr;
  logic [C_COUNT_W-1:0] rCount;
  logic [C_WIDTH-1:0]   rRdData;
  logic                 doWr, doRd;

  assign FULL    = (rCount == C_COUNT_W'(C_DEPTH));
  assign EMPTY   = (rCount == '0);
  assign doWr    = WR_EN && !FULL;
  assign doRd    = RD_EN && !EMPTY;
  assign RD_DATA = rRdData;

  function automatic logic [C_PTR_W-1:0] nextPtr(input logic [C_PTR_W-1:0] p);
    return (p == C_PTR_W'(C_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage array is left unreset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (doWr) mem[rWrPtr] <= WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rWrPtr  <= '0;
      rRdPtr  <= '0;
      rCount  <= '0;
      rRdData <= '0;
    end else begin
      if (doWr) rWrPtr <= nextPtr(rWrPtr);
      if (doRd) begin
        rRdPtr  <= nextPtr(rRdPtr);
        rRdData <= mem[rRdPtr];
      end
      case ({doWr, doRd})
        2'b10:   rCount <= rCount + 1'b1;
        2'b01:   rCount <= rCount - 1'b1;
        default: rCount <= rCount;
      endcase
    end
  end

  generate
    if (C_PROVIDE_COUNT != 0) begin : gCount
      assign COUNT = rCount;
    end else begin : gNoCount
      assign COUNT = '0;
    end
  endgenerate

endmodule

// File: rtl/rx_port_buffer_64.sv
// rx_port_buffer_64
//   RX-side port buffer: packs DW payload into 64-bit words, queues them
//   in a block-RAM FIFO and presents them through a 2-entry registered
//   first-word-fall-through output stage.
//   Ports: CLK, RST_N (sync, active-low)
//          WR_DATA/WR_EN/WR_FLUSH  payload beat from the RX engine
//          WR_COUNT                packed words held (FIFO + in flight +
//                                  output stage)
//          ERROR                   sticky overflow / flush-gap flag
//          RD_DATA/RD_DATA_VALID/RD_EN  channel read port
module rx_port_buffer_64
  import rx_port_buffer_pkg::*;
#(
  parameter int C_DATA_WIDTH        = 64,
  parameter int C_FIFO_DEPTH        = 512,
  localparam int C_FIFO_DEPTH_WIDTH = $clog2((2**$clog2(C_FIFO_DEPTH)) + 1)
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [C_DATA_WIDTH-1:0]       WR_DATA,
  input  logic [1:0]                    WR_EN,
  input  logic                          WR_FLUSH,
  output logic [C_FIFO_DEPTH_WIDTH-1:0] WR_COUNT,
  output logic                          ERROR,
  output logic [C_DATA_WIDTH-1:0]       RD_DATA,
  output logic                          RD_DATA_VALID,
  input  logic                          RD_EN
);

  localparam int CW = C_FIFO_DEPTH_WIDTH;

  generate
    if (C_DATA_WIDTH != 64) begin : gBadWidth
      $error("rx_port_buffer_64: C_DATA_WIDTH must be 64");
    end
  endgenerate

  logic [WORD_W-1:0] packWord;
  logic              packPush, packGapErr;

  rx_port_packer_64 uPacker (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wrData  (WR_DATA),
    .wrEn    (WR_EN),
    .wrFlush (WR_FLUSH),
    .word    (packWord),
    .push    (packPush),
    .gapErr  (packGapErr)
  );

  logic              fifoWr, fifoRd, fifoFull, fifoEmpty;
  logic [WORD_W-1:0] fifoRdData;
  logic [CW-1:0]     fifoCount;

  // Output stage: entry 0 is the head presented on RD_*.
  logic [WORD_W-1:0] rOut0, rOut1, nOut0, nOut1;
  logic              rV0, rV1, nV0, nV1;
  logic              rInFlight, rError;
  logic [1:0]        occ;
  logic [2:0]        used;
  logic              pop, roomLeft, overflow;

  assign occ      = {1'b0, rV0} + {1'b0, rV1};
  assign WR_COUNT = fifoCount + CW'(occ) + CW'(rInFlight);

  // Capacity is counted across FIFO, in-flight read and output stage, so a
  // full total drops the word even though the FIFO RAM itself has room.
  assign roomLeft = (WR_COUNT < CW'(C_FIFO_DEPTH));
  assign fifoWr   = packPush && roomLeft && !fifoFull;
  assign overflow = packPush && !fifoWr;

  assign pop    = RD_EN && rV0;
  // The slot freed by this cycle's pop is credited immediately so a
  // continuous read sustains one word per cycle.
  assign used   = {1'b0, occ} + {2'b00, rInFlight} - {2'b00, pop};
  assign fifoRd = !fifoEmpty && (used < 3'd2);

  sync_fifo #(
    .C_WIDTH         (WORD_W),
    .C_DEPTH         (C_FIFO_DEPTH),
    .C_PROVIDE_COUNT (1)
  ) uFifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .WR_EN   (fifoWr),
    .WR_DATA (packWord),
    .FULL    (fifoFull),
    .RD_EN   (fifoRd),
    .RD_DATA (fifoRdData),
    .EMPTY   (fifoEmpty),
    .COUNT   (fifoCount)
  );

  always_comb begin
    nOut0 = rOut0;
    nOut1 = rOut1;
    nV0   = rV0;
    nV1   = rV1;
    if (pop) begin
      nOut0 = rV1 ? rOut1 : rOut0;
      nV0   = rV1;
      nV1   = 1'b0;
    end
    // A read issued last cycle lands in the first free entry.
    if (rInFlight) begin
      if (!nV0) begin
        nOut0 = fifoRdData;
        nV0   = 1'b1;
      end else begin
        nOut1 = fifoRdData;
        nV1   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rOut0     <= '0;
      rOut1     <= '0;
      rV0       <= 1'b0;
      rV1       <= 1'b0;
      rInFlight <= 1'b0;
      rError    <= 1'b0;
    end else begin
      rOut0     <= nOut0;
      rOut1     <= nOut1;
      rV0       <= nV0;
      rV1       <= nV1;
      rInFlight <= fifoRd;
      rError    <= rError | overflow | packGapErr;
    end
  end

  assign RD_DATA       = rOut0;
  assign RD_DATA_VALID = rV0;
  assign ERROR         = rError;

endmodule

// File: tb/tb_rx_port_buffer_64.sv
module tb_rx_port_buffer_64;

  localparam int DEPTH = 512;
  localparam int CW    = 10;

  localparam logic [31:0] A = 32'hA0A0_0001;
  localparam logic [31:0] B = 32'hB0B0_0002;
  localparam logic [31:0] C = 32'hC0C0_0003;
  localparam logic [31:0] D = 32'hD0D0_0004;
  localparam logic [31:0] E = 32'hE0E0_0005;
  localparam logic [31:0] F = 32'hF0F0_0006;
  localparam logic [31:0] X = 32'h1111_0007;
  localparam logic [31:0] Y = 32'h2222_0008;
  localparam logic [31:0] Z = 32'h3333_0009;
  localparam logic [31:0] J = 32'hDEAD_BEEF;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [63:0]   WR_DATA;
  logic [1:0]    WR_EN;
  logic          WR_FLUSH;
  logic [CW-1:0] WR_COUNT;
  logic          ERROR;
  logic [63:0]   RD_DATA;
  logic          RD_DATA_VALID;
  logic          RD_EN;

  int errors = 0;
  int checks = 0;
  int peak   = 0;

  rx_port_buffer_64 #(.C_DATA_WIDTH(64), .C_FIFO_DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .WR_DATA       (WR_DATA),
    .WR_EN         (WR_EN),
    .WR_FLUSH      (WR_FLUSH),
    .WR_COUNT      (WR_COUNT),
    .ERROR         (ERROR),
    .RD_DATA       (RD_DATA),
    .RD_DATA_VALID (RD_DATA_VALID),
    .RD_EN         (RD_EN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] pat(input int i);
    return {32'(2 * i + 1) ^ 32'h5A00_0000, 32'(2 * i)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (int'(WR_COUNT) > peak) peak = int'(WR_COUNT);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] en, input logic [63:0] d, input logic fl);
    WR_EN    = en;
    WR_DATA  = d;
    WR_FLUSH = fl;
    tick();
    WR_EN    = 2'b00;
    WR_DATA  = '0;
    WR_FLUSH = 1'b0;
  endtask

  // Waits (bounded) for a valid word, checks it, then advances one cycle.
  task automatic getWord(input string tag, input logic [63:0] exp, output int waited);
    waited = 0;
    while (!RD_DATA_VALID && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, ".valid"}, 64'(RD_DATA_VALID), 64'd1);
    chk({tag, ".data"}, RD_DATA, exp);
    tick();
  endtask

  task automatic noMoreWords(input string tag, input int cycles);
    logic seen;
    seen = RD_DATA_VALID;
    repeat (cycles) begin
      tick();
      seen = seen | RD_DATA_VALID;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int w;
    RST_N    = 1'b0;
    WR_EN    = 2'b00;
    WR_DATA  = '0;
    WR_FLUSH = 1'b0;
    RD_EN    = 1'b0;
    repeat (2) tick();
    chk("rst.valid", 64'(RD_DATA_VALID), 64'd0);
    chk("rst.data",  RD_DATA,            64'd0);
    chk("rst.count", 64'(WR_COUNT),      64'd0);
    chk("rst.error", 64'(ERROR),         64'd0);
    RST_N = 1'b1;
    tick();

    // Two full beats, latency and peak count.
    RD_EN = 1'b1;
    peak  = 0;
    beat(2'b11, {B, A}, 1'b0);
    getWord("t1.w0", {B, A}, w);
    chk("t1.latency0", 64'(w), 64'd3);
    beat(2'b11, {D, C}, 1'b0);
    getWord("t1.w1", {D, C}, w);
    chk("t1.latency1", 64'(w), 64'd3);
    noMoreWords("t1.extra", 3);
    chk("t1.peak", 64'(peak), 64'd1);

    // Single-DW beats including DW1-only, flush with one DW.
    beat(2'b01, {J, A}, 1'b0);
    beat(2'b10, {B, J}, 1'b0);
    beat(2'b01, {J, C}, 1'b1);
    getWord("t2.w0", {B, A}, w);
    chk("t2.wait0", 64'(w), 64'd2);
    getWord("t2.w1", {32'd0, C}, w);
    chk("t2.wait1", 64'(w), 64'd0);
    noMoreWords("t2.extra", 4);

    // Residue + full beat + flush -> FLUSH_PEND for exactly one cycle.
    beat(2'b01, {J, A}, 1'b0);
    beat(2'b11, {C, B}, 1'b1);
    getWord("t3.w0", {B, A}, w);
    chk("t3.wait0", 64'(w), 64'd3);
    getWord("t3.w1", {32'd0, C}, w);
    chk("t3.wait1", 64'(w), 64'd0);
    noMoreWords("t3.extra", 4);
    chk("t3.error", 64'(ERROR), 64'd0);

    // Flush-gap violation: X,Y dropped, pending word still delivered.
    beat(2'b01, {J, A}, 1'b0);
    beat(2'b11, {C, B}, 1'b1);
    beat(2'b11, {Y, X}, 1'b0);
    getWord("t4.w0", {B, A}, w);
    chk("t4.wait0", 64'(w), 64'd2);
    getWord("t4.w1", {32'd0, C}, w);
    chk("t4.wait1", 64'(w), 64'd0);
    noMoreWords("t4.extra", 4);
    chk("t4.error", 64'(ERROR), 64'd1);
    beat(2'b01, {J, E}, 1'b1);
    getWord("t4.clean", {32'd0, E}, w);

    // Reset mid-transfer with words buffered and a residue held.
    RD_EN = 1'b0;
    beat(2'b11, pat(0), 1'b0);
    beat(2'b11, pat(1), 1'b0);
    beat(2'b11, pat(2), 1'b0);
    beat(2'b01, {J, Z}, 1'b0);
    repeat (4) tick();
    chk("t6.pre.count", 64'(WR_COUNT), 64'd3);
    chk("t6.pre.valid", 64'(RD_DATA_VALID), 64'd1);
    chk("t6.pre.error", 64'(ERROR), 64'd1);
    RST_N = 1'b0;
    tick();
    chk("t6.rst.valid", 64'(RD_DATA_VALID), 64'd0);
    chk("t6.rst.data",  RD_DATA,            64'd0);
    chk("t6.rst.count", 64'(WR_COUNT),      64'd0);
    chk("t6.rst.error", 64'(ERROR),         64'd0);
    RST_N = 1'b1;
    RD_EN = 1'b1;
    beat(2'b11, {F, E}, 1'b1);
    getWord("t6.fresh", {F, E}, w);
    chk("t6.latency", 64'(w), 64'd3);
    noMoreWords("t6.extra", 4);

    // Overflow: fill to capacity with RD_EN low, then two excess words.
    RD_EN = 1'b0;
    for (int i = 0; i < DEPTH; i++) beat(2'b11, pat(i), 1'b0);
    repeat (2) tick();
    chk("t5.full.count", 64'(WR_COUNT), 64'(DEPTH));
    chk("t5.full.error", 64'(ERROR), 64'd0);
    beat(2'b11, pat(DEPTH), 1'b0);
    beat(2'b11, pat(DEPTH + 1), 1'b0);
    repeat (3) tick();
    chk("t5.ovf.count", 64'(WR_COUNT), 64'(DEPTH));
    chk("t5.ovf.error", 64'(ERROR), 64'd1);
    chk("t5.ovf.valid", 64'(RD_DATA_VALID), 64'd1);
    RD_EN = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("t5.drain%0d.valid", i), 64'(RD_DATA_VALID), 64'd1);
      chk($sformatf("t5.drain%0d.data", i), RD_DATA, pat(i));
      tick();
    end
    chk("t5.end.valid", 64'(RD_DATA_VALID), 64'd0);
    chk("t5.end.count", 64'(WR_COUNT), 64'd0);
    noMoreWords("t5.extra", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
